// File: rtl/tb_mailbox_mon.sv
// tb_mailbox_mon: watches LSU AHB-Lite writes to the mailbox, queues printable bytes, raises pass/fail flags.
// Define MBOX_TIMEOUT_EN to build the saturating cycle counter and the timeout flag.
module tb_mailbox_mon #(
    parameter logic [31:0] MBOX_ADDR  = 32'hD058_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] MAX_CYCLES = 32'h0000_0800
) (
    input  logic        core_clk,
    input  logic        reset_l,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [63:0] hwdata,
    input  logic        hready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        finished,
    output logic        failed,
    output logic        overflow,
    output logic        timeout
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic          ap_hit_r;
    logic [2:0]    ap_lane_r;
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic          finished_r;
    logic          failed_r;
    logic          overflow_r;
    logic          dp_done_s;
    logic [7:0]    byte_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          wr_en_s;
    logic          unused_s;

    // Size and the SEQ/NONSEQ distinction do not affect decoding.
    assign unused_s = ^{hsize, htrans[0]};

    // Address-phase capture; holds across wait states.
    always_ff @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) begin
            ap_hit_r  <= 1'b0;
            ap_lane_r <= 3'b000;
        end else if (hready) begin
            if (htrans[1]) begin
                ap_hit_r  <= hwrite & (haddr[31:3] == MBOX_ADDR[31:3]);
                ap_lane_r <= haddr[2:0];
            end else begin
                ap_hit_r  <= 1'b0;
            end
        end
    end

    // Data-phase byte extraction, classification and FIFO handshakes.
    always_comb begin
        dp_done_s = hready & ap_hit_r;
        byte_s    = hwdata[{ap_lane_r, 3'b000} +: 8];
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        push_s    = dp_done_s && (byte_s > 8'h05) && (byte_s < 8'h7F);
        pop_s     = char_ready & ~empty_s;
        wr_en_s   = push_s & (~full_s | pop_s);
    end

    // FIFO storage and pointers; pointers wrap naturally through the extra MSB.
    always_ff @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= byte_s;
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Sticky completion and drop flags.
    always_ff @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) begin
            finished_r <= 1'b0;
            failed_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (dp_done_s && (byte_s == 8'hFF)) begin
                finished_r <= 1'b1;
            end
            if (dp_done_s && (byte_s == 8'h01)) begin
                failed_r <= 1'b1;
            end
            if (push_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign char_valid = ~empty_s;
    assign char_data  = mem_r[rd_ptr_r[AW-1:0]];
    assign finished   = finished_r;
    assign failed     = failed_r;
    assign overflow   = overflow_r;

`ifdef MBOX_TIMEOUT_EN
    logic [31:0] cyc_cnt_r;
    logic [31:0] cyc_next_s;
    logic        timeout_r;

    assign cyc_next_s = cyc_cnt_r + 32'd1;

    // Saturating run-time counter; frozen once the test reports an outcome.
    always_ff @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) begin
            cyc_cnt_r <= 32'd0;
            timeout_r <= 1'b0;
        end else if (!finished_r && !failed_r && (cyc_cnt_r != MAX_CYCLES)) begin
            cyc_cnt_r <= cyc_next_s;
            if (cyc_next_s == MAX_CYCLES) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tb_mailbox_mon.sv
// Directed bench for tb_mailbox_mon: mailbox decode, wait states, FIFO full/wrap, control bytes, reset, timeout.
module tb_tb_mailbox_mon;
    localparam logic [31:0] MBOX = 32'hD058_0000;

    logic        core_clk = 1'b0;
    logic        reset_l;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [63:0] hwdata;
    logic        hready;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        finished;
    logic        failed;
    logic        overflow;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    tb_mailbox_mon #(
        .MBOX_ADDR  (MBOX),
        .FIFO_DEPTH (16),
        .MAX_CYCLES (32'd100)
    ) dut (
        .core_clk   (core_clk),
        .reset_l    (reset_l),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .hready     (hready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .finished   (finished),
        .failed     (failed),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    // Free-running bench clock.
    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic bus_idle();
        haddr  = 32'h0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hready = 1'b1;
    endtask

    task automatic do_reset();
        reset_l    = 1'b0;
        bus_idle();
        hwdata     = 64'h0;
        char_ready = 1'b0;
        tick();
        tick();
        reset_l = 1'b1;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [63:0] d, input logic wr, input int waits);
        haddr  = a;
        htrans = 2'b10;
        hwrite = wr;
        hready = 1'b1;
        tick();
        bus_idle();
        hwdata = d;
        hready = 1'b0;
        for (int i = 0; i < waits; i++) tick();
        hready = 1'b1;
        tick();
        hwdata = 64'h0;
    endtask

    // Cycle i of a pipelined burst: address phase of byte i, data phase of byte i-1.
    task automatic drive_burst(input int i, input int n, input logic [7:0] base);
        hready = 1'b1;
        if (i < n) begin
            haddr  = MBOX;
            htrans = (i == 0) ? 2'b10 : 2'b11;
            hwrite = 1'b1;
        end else begin
            haddr  = 32'h0;
            htrans = 2'b00;
            hwrite = 1'b0;
        end
        hwdata = (i >= 1 && i <= n) ? {56'h0, base + 8'(i - 1)} : 64'h0;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        tick();
        n_checks++;
        if ({char_valid, char_data, finished, failed, overflow, timeout} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {char_valid, char_data, finished, failed, overflow, timeout});
        end
        reset_l = 1'b1;
    endtask

    task automatic test_single_write();
        haddr = MBOX; htrans = 2'b10; hwrite = 1'b1; hready = 1'b1;
        tick();
        bus_idle();
        hwdata = 64'h41;
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_valid: got %b expected 0", char_valid);
        end
        tick();
        hwdata = 64'h0;
        n_checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h41) begin
            n_fail++;
            $display("FAIL single_data: got v=%b d=%h expected v=1 d=41", char_valid, char_data);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL single_overflow: got %b expected 0", overflow);
        end
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: got %b expected 0", char_valid);
        end
    endtask

    task automatic test_wait_states();
        haddr = MBOX + 32'd3; htrans = 2'b10; hwrite = 1'b1; hready = 1'b1;
        tick();
        bus_idle();
        hwdata = 64'h4800_0000;
        hready = 1'b0;
        for (int w = 0; w < 2; w++) begin
            tick();
            n_checks++;
            if (char_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_early_push: got %b expected 0 (wait %0d)", char_valid, w);
            end
        end
        hready = 1'b1;
        tick();
        hwdata = 64'h0;
        n_checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h48) begin
            n_fail++;
            $display("FAIL wait_data: got v=%b d=%h expected v=1 d=48", char_valid, char_data);
        end
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_single_push: got %b expected 0", char_valid);
        end
    endtask

    task automatic test_overflow();
        char_ready = 1'b0;
        for (int i = 0; i <= 17; i++) begin
            drive_burst(i, 17, 8'h41);
            tick();
            n_checks++;
            if (overflow !== (i >= 17)) begin
                n_fail++;
                $display("FAIL ovf_flag: got %b expected %b after %0d bytes", overflow, (i >= 17), i);
            end
        end
        bus_idle();
        hwdata = 64'h0;
        char_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (char_valid !== 1'b1 || char_data !== 8'h41 + 8'(k)) begin
                n_fail++;
                $display("FAIL ovf_order: got v=%b d=%h expected v=1 d=%h", char_valid, char_data, 8'h41 + 8'(k));
            end
            tick();
        end
        char_ready = 1'b0;
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drained: got %b expected 0", char_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i <= 40; i++) begin
            drive_burst(i, 40, 8'h20);
            char_ready = (i >= 17);
            if (i >= 17) begin
                n_checks++;
                if (char_valid !== 1'b1 || char_data !== 8'h20 + 8'(i - 17)) begin
                    n_fail++;
                    $display("FAIL b2b_head: got v=%b d=%h expected v=1 d=%h", char_valid, char_data, 8'h20 + 8'(i - 17));
                end
            end
            tick();
            n_checks++;
            if (overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_overflow: got %b expected 0 at cycle %0d", overflow, i);
            end
        end
        bus_idle();
        hwdata = 64'h0;
        for (int k = 24; k < 40; k++) begin
            n_checks++;
            if (char_valid !== 1'b1 || char_data !== 8'h20 + 8'(k)) begin
                n_fail++;
                $display("FAIL b2b_drain: got v=%b d=%h expected v=1 d=%h", char_valid, char_data, 8'h20 + 8'(k));
            end
            tick();
        end
        char_ready = 1'b0;
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got %b expected 0", char_valid);
        end
    endtask

    task automatic test_control();
        do_reset();
        ahb_write(MBOX, 64'hFF, 1'b1, 0);
        n_checks++;
        if (finished !== 1'b1 || failed !== 1'b0 || char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ctl_finished: got f=%b x=%b v=%b expected f=1 x=0 v=0", finished, failed, char_valid);
        end
        ahb_write(MBOX, 64'h01, 1'b1, 0);
        n_checks++;
        if (failed !== 1'b1 || finished !== 1'b1 || char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ctl_failed: got x=%b f=%b v=%b expected x=1 f=1 v=0", failed, finished, char_valid);
        end
        ahb_write(MBOX + 32'd8, 64'h41, 1'b1, 0);
        ahb_write(MBOX, 64'h41, 1'b0, 0);
        ahb_write(MBOX, 64'h05, 1'b1, 0);
        ahb_write(MBOX, 64'h7F, 1'b1, 0);
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ctl_no_push: got %b expected 0", char_valid);
        end
        ahb_write(MBOX, 64'h06, 1'b1, 0);
        ahb_write(MBOX, 64'h7E, 1'b1, 0);
        ahb_write(MBOX + 32'd5, 64'h4343_5543_4343_4343, 1'b1, 1);
        char_ready = 1'b1;
        n_checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h06) begin
            n_fail++;
            $display("FAIL ctl_low_edge: got v=%b d=%h expected v=1 d=06", char_valid, char_data);
        end
        tick();
        n_checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h7E) begin
            n_fail++;
            $display("FAIL ctl_high_edge: got v=%b d=%h expected v=1 d=7e", char_valid, char_data);
        end
        tick();
        n_checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h55) begin
            n_fail++;
            $display("FAIL ctl_lane5: got v=%b d=%h expected v=1 d=55", char_valid, char_data);
        end
        tick();
        char_ready = 1'b0;
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ctl_empty: got %b expected 0", char_valid);
        end
    endtask

    task automatic test_reset_mid();
        haddr = MBOX; htrans = 2'b10; hwrite = 1'b1; hready = 1'b1;
        tick();
        bus_idle();
        hwdata  = 64'h41;
        reset_l = 1'b0;
        #1;
        n_checks++;
        if ({finished, failed, overflow, char_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_flags: got %b expected 0000", {finished, failed, overflow, char_valid});
        end
        @(negedge core_clk);
        reset_l = 1'b1;
        tick();
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release_capture: got %b expected 0", char_valid);
        end
        hwdata = 64'h0;
        tick();
        n_checks++;
        if (char_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pending_dropped: got %b expected 0", char_valid);
        end
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef MBOX_TIMEOUT_EN
        for (int c = 1; c <= 102; c++) begin
            tick();
            n_checks++;
            if (timeout !== (c >= 100)) begin
                n_fail++;
                $display("FAIL timeout_edge: got %b expected %b at cycle %0d", timeout, (c >= 100), c);
            end
        end
`else
        for (int c = 0; c < 120; c++) tick();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_off: got %b expected 0", timeout);
        end
`endif
    endtask

    // Stimulus sequence and final summary.
    initial begin
        reset_l    = 1'b1;
        hsize      = 3'b000;
        hwdata     = 64'h0;
        char_ready = 1'b0;
        bus_idle();
        #2;
        test_reset();
        test_single_write();
        test_wait_states();
        test_overflow();
        test_back_to_back();
        test_control();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
